fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch stage of the pipelined RV32I core; sits directly upstream of the instruction ROM.
- Owns the PC. Issues a word address and request to the ROM each cycle, and captures the returned instruction into the IF/ID register.
- Handles pipeline stall, branch/jump redirect with flush, and halt-on-EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EBREAK_INSTR, 32'h0010_0073, encoding that halts fetch.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- stall  in  1  hold PC and IF/ID, from hazard unit.
- redirect  in  1  taken branch/jump, from EX.
- redirect_pc  in  WIDTH  redirect target.
- imem_addr  out  WIDTH  byte address to the ROM; the ROM word-aligns it.
- imem_req  out  1  fetch request.
- imem_valid  in  1  ROM response valid, same cycle as imem_req.
- imem_instr  in  WIDTH  ROM data.
- if_id_valid  out  1  IF/ID slot holds a real instruction.
- if_id_pc  out  WIDTH  PC of the IF/ID instruction.
- if_id_instr  out  WIDTH  IF/ID instruction (NOP 32'h0000_0013 when invalid).
- halted  out  1  fetch has stopped on EBREAK or trap.
- fetch_misaligned  out  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=BOOT.
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP.
  - halted=0, fetch_misaligned=0.
- FSM states:
  - BOOT: one cycle, no request (imem_req=0); then goes to RUN.
  - RUN: normal fetch.
  - HALTED: terminal until reset.
- Combinational outputs:
  - imem_addr=pc always.
  - imem_req = (state==RUN) && !stall && !redirect.
- RUN, per rising edge, priority high to low:
  - 1. redirect: pc<=redirect_pc; IF/ID flushed (valid=0, instr=NOP). Applies even if stall=1.
  - 2. stall: pc and IF/ID hold.
  - 3. imem_valid=1: IF/ID<={1, pc, imem_instr}; pc<=pc+4.
    - If imem_instr==EBREAK_INSTR, the EBREAK is still written to IF/ID and state<=HALTED.
  - 4. imem_valid=0: pc holds; IF/ID gets a bubble (valid=0).
- Latency: ROM is combinational, so the instruction at PC appears in IF/ID one clock after the request. Throughput is one instruction per cycle.
- PC arithmetic:
  - pc+4 is modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.
  - pc[1:0] is always 2'b00.
- HALTED:
  - imem_req=0, halted=1, pc frozen.
  - IF/ID flushes to a bubble on the first HALTED cycle unless stall=1; it then holds the bubble.
  - redirect is ignored.
- Redirect during BOOT: pc<=redirect_pc; state still moves to RUN.
- Reset asserted mid-operation: all state returns to reset values immediately, with no clock required.

Optional Feature:
- Macro FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 does not update pc.
  - fetch_misaligned pulses for one cycle (registered), IF/ID is flushed, and state<=HALTED.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 when loaded.
  - fetch_misaligned is tied to 0.

Decomposition:
- Shared package all_pkgs:
  - WIDTH (existing).
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {BOOT, RUN, HALTED}.
  - if_id_t packed struct {valid, pc, instr}, reused by the decode stage.
- Sub-module pc_gen: the PC register and next-PC mux (redirect, hold, +4), with the FSM kept in fetch_unit.

Test Plan:
- Reset then free-run with ROM words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x00000013:
  - imem_req=0 for the first cycle after reset release.
  - if_id_pc sequence 0,4,8,C with matching instructions, if_id_valid=1 from the third cycle.
- stall=1 for 3 cycles at pc=8: imem_req=0, pc stays 8, IF/ID holds pc=4/0x00A00113; fetch resumes at 8.
- redirect=1, redirect_pc=0x40 together with stall=1: next cycle pc=0x40 and if_id_valid=0; following cycle if_id_pc=0x40.
- ROM word 2 = 0x00100073:
  - if_id_instr=0x00100073 at pc=8, then halted=1, imem_req=0 permanently.
  - A redirect to 0x0 is ignored.
- pc forced to 0xFFFFFFFC via redirect: next fetched pc=0x00000000.
- Redirect to 0x42:
  - With FETCH_ALIGN_CHK_EN: fetch_misaligned=1 for one cycle and halted=1.
  - Without it: pc=0x40.

Source files
------------

// File: rtl/all_pkgs.sv
// all_pkgs: types and constants shared by the fetch and decode stages.
//   WIDTH         - datapath / address width of the core.
//   NOP_INSTR     - canonical ADDI x0,x0,0 used to fill empty pipeline slots.
//   fetch_state_t - fetch FSM states.
//   if_id_t       - IF/ID pipeline register contents (also consumed by decode).
//   pc_sel_t      - next-PC mux select for pc_gen.
package all_pkgs;

   localparam int unsigned WIDTH = 32;
   localparam logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED
   } fetch_state_t;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } if_id_t;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_LOAD,
      PC_INCR
   } pc_sel_t;

   // Empty IF/ID slot: not valid, carries a NOP so decode sees harmless bits.
   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b.valid = 1'b0;
      b.pc    = '0;
      b.instr = NOP_INSTR;
      return b;
   endfunction

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// pc_gen: program counter register and next-PC mux for the fetch stage.
// Ports:
//   clk       - core clock
//   rst_n     - asynchronous active-low reset, loads RESET_PC
//   pc_sel_i  - hold / load redirect target / advance by one word
//   load_pc_i - redirect target (already word-aligned by the caller)
//   pc_o      - current PC
module pc_gen
   import all_pkgs::*;
#(
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  pc_sel_t          pc_sel_i,
   input  logic [WIDTH-1:0] load_pc_i,
   output logic [WIDTH-1:0] pc_o
);

   logic [WIDTH-1:0] pc_d, pc_q;

   // The +4 wraps naturally modulo 2^WIDTH.
   always_comb begin
      pc_d = pc_q;
      unique case (pc_sel_i)
         PC_HOLD: pc_d = pc_q;
         PC_LOAD: pc_d = load_pc_i;
         PC_INCR: pc_d = pc_q + WIDTH'(4);
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the RV32I pipeline. Owns the PC, requests words from a
// combinational instruction ROM and captures them into the IF/ID register.
// Handles stall, redirect-with-flush and halt on EBREAK.
// Optional build macro: FETCH_ALIGN_CHK_EN - a misaligned redirect halts fetch and
// pulses fetch_misaligned; without it the target's low two bits are dropped.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   stall                     - hold PC and IF/ID (hazard unit)
//   redirect, redirect_pc     - taken branch/jump from EX and its target
//   imem_addr, imem_req       - ROM byte address and request
//   imem_valid, imem_instr    - ROM response (same cycle as request)
//   if_id_valid/pc/instr      - IF/ID register contents
//   halted                    - fetch stopped (EBREAK or misaligned trap)
//   fetch_misaligned          - one-cycle pulse on a misaligned redirect
module fetch_unit
   import all_pkgs::*;
#(
   parameter logic [WIDTH-1:0] RESET_PC     = 32'h0000_0000,
   parameter logic [WIDTH-1:0] EBREAK_INSTR = 32'h0010_0073
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic [WIDTH-1:0] imem_addr,
   output logic             imem_req,
   input  logic             imem_valid,
   input  logic [WIDTH-1:0] imem_instr,
   output logic             if_id_valid,
   output logic [WIDTH-1:0] if_id_pc,
   output logic [WIDTH-1:0] if_id_instr,
   output logic             halted,
   output logic             fetch_misaligned
);

   fetch_state_t     state_d, state_q;
   if_id_t           if_id_d, if_id_q;
   logic             misaligned_d, misaligned_q;
   pc_sel_t          pc_sel;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] load_pc;
   logic             bad_redirect;

   assign load_pc = {redirect_pc[WIDTH-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
   assign bad_redirect = redirect && (redirect_pc[1:0] != 2'b00);
`else
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign bad_redirect         = 1'b0;
`endif

   pc_gen #(
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc_sel_i  (pc_sel),
      .load_pc_i (load_pc),
      .pc_o      (pc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus PC / IF/ID datapath control.
   always_comb begin
      state_d      = state_q;
      pc_sel       = PC_HOLD;
      if_id_d      = if_id_q;
      misaligned_d = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
            if (redirect) begin
               if (bad_redirect) begin
                  misaligned_d = 1'b1;
                  state_d      = HALTED;
               end else begin
                  pc_sel = PC_LOAD;
               end
            end
         end
         RUN: begin
            // Redirect wins over stall: the wrong-path slot must be killed.
            if (redirect) begin
               if_id_d = if_id_bubble();
               if (bad_redirect) begin
                  misaligned_d = 1'b1;
                  state_d      = HALTED;
               end else begin
                  pc_sel = PC_LOAD;
               end
            end else if (stall) begin
               if_id_d = if_id_q;
            end else if (imem_valid) begin
               if_id_d.valid = 1'b1;
               if_id_d.pc    = pc;
               if_id_d.instr = imem_instr;
               pc_sel        = PC_INCR;
               // EBREAK still reaches decode; fetch stops behind it.
               if (imem_instr == EBREAK_INSTR) begin
                  state_d = HALTED;
               end
            end else begin
               if_id_d = if_id_bubble();
            end
         end
         HALTED: begin
            if (!stall) begin
               if_id_d = if_id_bubble();
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      imem_req = (state_q == RUN) && !stall && !redirect;
      halted   = (state_q == HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_q      <= if_id_bubble();
         misaligned_q <= 1'b0;
      end else begin
         if_id_q      <= if_id_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign imem_addr        = pc;
   assign if_id_valid      = if_id_q.valid;
   assign if_id_pc         = if_id_q.pc;
   assign if_id_instr      = if_id_q.instr;
   assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a random
// phase, every cycle compared against a cycle-level behavioural model.
module tb_fetch_unit;
   import all_pkgs::*;

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_instr;
   logic        imem_req, imem_valid;
   logic        if_id_valid;
   logic [31:0] if_id_pc, if_id_instr;
   logic        halted, fetch_misaligned;

   logic        vld_en;
   logic [31:0] rom [64];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Combinational ROM, answering in the request cycle.
   assign imem_valid = imem_req & vld_en;
   assign imem_instr = rom[imem_addr[7:2]];

   fetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .imem_addr        (imem_addr),
      .imem_req         (imem_req),
      .imem_valid       (imem_valid),
      .imem_instr       (imem_instr),
      .if_id_valid      (if_id_valid),
      .if_id_pc         (if_id_pc),
      .if_id_instr      (if_id_instr),
      .halted           (halted),
      .fetch_misaligned (fetch_misaligned)
   );

   // Reference model state.
   bit          m_boot, m_halt, m_v, m_mis;
   logic [31:0] m_pc, m_ipc, m_ins;

   task automatic model_reset();
      m_boot = 1; m_halt = 0; m_v = 0; m_mis = 0;
      m_pc = 32'h0; m_ipc = 32'h0; m_ins = NOP;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit exp_req;
      exp_req = !m_boot && !m_halt && !stall && !redirect;
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      check("imem_addr", imem_addr, m_pc);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
      check("if_id_instr", if_id_instr, m_ins);
      if (m_v) check("if_id_pc", if_id_pc, m_ipc);
      check("halted", {31'b0, halted}, {31'b0, m_halt});
      check("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
   endtask

   // One clock: check at negedge, predict the edge, commit after it.
   task automatic tick();
      bit          n_boot, n_halt, n_v, n_mis, mis;
      logic [31:0] n_pc, n_ipc, n_ins, word;
      @(negedge clk);
      check_all();
      n_boot = m_boot; n_halt = m_halt; n_v = m_v; n_mis = 0;
      n_pc = m_pc; n_ipc = m_ipc; n_ins = m_ins;
`ifdef FETCH_ALIGN_CHK_EN
      mis = redirect && (redirect_pc[1:0] != 2'b00);
`else
      mis = 0;
`endif
      word = rom[m_pc[7:2]];
      if (m_boot) begin
         n_boot = 0;
         if (redirect) begin
            if (mis) begin n_mis = 1; n_halt = 1; end
            else n_pc = redirect_pc & ~32'h3;
         end
      end else if (m_halt) begin
         if (!stall) begin n_v = 0; n_ins = NOP; end
      end else if (redirect) begin
         n_v = 0; n_ins = NOP;
         if (mis) begin n_mis = 1; n_halt = 1; end
         else n_pc = redirect_pc & ~32'h3;
      end else if (stall) begin
         // everything holds
      end else if (vld_en) begin
         n_v = 1; n_ipc = m_pc; n_ins = word; n_pc = m_pc + 32'd4;
         if (word == EBREAK) n_halt = 1;
      end else begin
         n_v = 0; n_ins = NOP;
      end
      @(posedge clk);
      #1;
      m_boot = n_boot; m_halt = n_halt; m_v = n_v; m_mis = n_mis;
      m_pc = n_pc; m_ipc = n_ipc; m_ins = n_ins;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 64; i++) rom[i] = NOP;
      rom[0] = 32'h0050_0093;
      rom[1] = 32'h00A0_0113;
      rom[2] = 32'h0020_81B3;
      rom[3] = 32'h0000_0013;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; vld_en = 1;
      load_prog();
      model_reset();
      #12;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1;

      // Free run, then a 3-cycle stall at pc=8.
      repeat (3) tick();
      check("pc_before_stall", imem_addr, 32'h8);
      check("ifid_before_stall", if_id_instr, 32'h00A0_0113);
      stall = 1;
      repeat (3) tick();
      stall = 0;
      repeat (3) tick();

      // Redirect together with stall.
      redirect = 1; stall = 1; redirect_pc = 32'h40;
      tick();
      redirect = 0; stall = 0;
      check("redirect_pc_loaded", imem_addr, 32'h40);
      repeat (2) tick();

      // PC wrap at the top of the address space.
      redirect = 1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 0;
      repeat (3) tick();

      // Dropped ROM responses.
      for (int i = 0; i < 20; i++) begin
         vld_en = ($urandom_range(0, 3) != 0);
         tick();
      end
      vld_en = 1;
      repeat (2) tick();

      // Asynchronous reset mid-run, then EBREAK halt.
      rom[2] = EBREAK;
      do_reset();
      repeat (6) tick();
      redirect = 1; redirect_pc = 32'h0;
      tick();
      redirect = 0; stall = 1;
      tick();
      stall = 0;
      repeat (2) tick();
      check("halt_sticky", {31'b0, halted}, 32'h1);

      // Misaligned redirect.
      load_prog();
      do_reset();
      repeat (3) tick();
      redirect = 1; redirect_pc = 32'h42;
      tick();
      redirect = 0;
      repeat (3) tick();

      // Random phase.
      for (int i = 0; i < 64; i++) begin
         rom[i] = $urandom;
         if (rom[i] == EBREAK) rom[i] = NOP;
      end
      do_reset();
      for (int i = 0; i < 400; i++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 9) == 0);
         redirect_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         vld_en      = ($urandom_range(0, 4) != 0);
         tick();
      end
      stall = 0; redirect = 0; vld_en = 1;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
